// File: rtl/usr_seq_pkg.sv
// usr_seq_pkg: opcodes, shift-register S codes, FSM encoding and decode helpers.
// ROR/ROL decode only when USR_SEQ_ROTATE_EN is defined.
package usr_seq_pkg;

   localparam logic [2:0] OP_NOP  = 3'd0;
   localparam logic [2:0] OP_LOAD = 3'd1;
   localparam logic [2:0] OP_SHR  = 3'd2;
   localparam logic [2:0] OP_SHL  = 3'd3;
   localparam logic [2:0] OP_INV  = 3'd4;
   localparam logic [2:0] OP_ROR  = 3'd5;
   localparam logic [2:0] OP_ROL  = 3'd6;
   localparam logic [2:0] OP_RSV  = 3'd7;

   localparam logic [2:0] S_HOLD  = 3'b000;
   localparam logic [2:0] S_SHR   = 3'b001;
   localparam logic [2:0] S_SHL   = 3'b010;
   localparam logic [2:0] S_LOAD  = 3'b011;
   localparam logic [2:0] S_INV   = 3'b100;
   localparam logic [2:0] S_ROR   = 3'b101;
   localparam logic [2:0] S_ROL   = 3'b110;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_CAPT = 2'd2
   } state_t;

   function automatic logic is_legal(input logic [2:0] op);
      logic ok;
      case (op)
         OP_NOP, OP_LOAD, OP_SHR,
         OP_SHL, OP_INV:  ok = 1'b1;
`ifdef USR_SEQ_ROTATE_EN
         OP_ROR, OP_ROL:  ok = 1'b1;
`endif
         default:         ok = 1'b0;
      endcase
      return ok;
   endfunction

   // Illegal or unmapped opcodes fall back to hold, so 111 never appears.
   function automatic logic [2:0] op_to_s(input logic [2:0] op);
      logic [2:0] s;
      case (op)
         OP_LOAD: s = S_LOAD;
         OP_SHR:  s = S_SHR;
         OP_SHL:  s = S_SHL;
         OP_INV:  s = S_INV;
`ifdef USR_SEQ_ROTATE_EN
         OP_ROR:  s = S_ROR;
         OP_ROL:  s = S_ROL;
`endif
         default: s = S_HOLD;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/usr_cmd_sequencer_if.sv
// usr_cmd_sequencer_if: command handshake plus shift-register S/I/O bus.
// master = host + shift register side, slave = sequencer.
interface usr_cmd_sequencer_if #(
   parameter int WIDTH = 4,
   parameter int CNT_W = 3
);
   logic             cmd_valid;
   logic             cmd_ready;
   logic [2:0]       cmd_op;
   logic [WIDTH-1:0] cmd_data;
   logic [CNT_W-1:0] cmd_count;
   logic [2:0]       sr_S;
   logic [WIDTH-1:0] sr_I;
   logic [WIDTH-1:0] sr_O;
   logic             done;
   logic             err;
   logic [WIDTH-1:0] result;

   modport master (
      output cmd_valid, cmd_op, cmd_data, cmd_count, sr_O,
      input  cmd_ready, sr_S, sr_I, done, err, result
   );

   modport slave (
      input  cmd_valid, cmd_op, cmd_data, cmd_count, sr_O,
      output cmd_ready, sr_S, sr_I, done, err, result
   );
endinterface

// File: rtl/usr_step_cnt.sv
// usr_step_cnt: loadable down-counter holding the remaining RUN steps.
// zero flags the cycle in which the last step is being driven.
module usr_step_cnt #(
   parameter int CNT_W = 3
) (
   input  logic             clk,
   input  logic             clear,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   input  logic             dec,
   output logic             zero
);
   localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

   logic [CNT_W-1:0] cnt;

   // Load on accept, count down once per RUN cycle, saturate at zero.
   always_ff @(posedge clk or negedge clear) begin
      if (!clear)
         cnt <= '0;
      else if (load)
         cnt <= load_val;
      else if (dec && cnt != '0)
         cnt <= cnt - ONE;
   end

   assign zero = (cnt == '0);
endmodule

// File: rtl/usr_cmd_sequencer.sv
// usr_cmd_sequencer: drives a universal shift register through one command.
// Define USR_SEQ_ROTATE_EN to enable ROR/ROL; otherwise they report err.
module usr_cmd_sequencer
   import usr_seq_pkg::*;
#(
   parameter int WIDTH = 4,
   parameter int CNT_W = 3
) (
   input logic               clk,
   input logic               clear,
   usr_cmd_sequencer_if.slave bus
);
   localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

   state_t           state, state_nxt;
   logic             accept;
   logic [CNT_W-1:0] steps_in;
   logic             cnt_zero;
   logic [2:0]       op_q;
   logic             ill_q;
   logic [2:0]       s_q, s_nxt;
   logic [WIDTH-1:0] i_q;
   logic [WIDTH-1:0] res_q;
   logic             done_q, done_nxt;
   logic             err_q, err_nxt;

   assign accept = bus.cmd_valid && (state == ST_IDLE);

   // Step count of the incoming command; illegal commands take no steps.
   always_comb begin
      steps_in = '0;
      if (is_legal(bus.cmd_op)) begin
         case (bus.cmd_op)
            OP_LOAD, OP_INV:  steps_in = ONE;
            OP_SHR, OP_SHL,
            OP_ROR, OP_ROL:   steps_in = bus.cmd_count;
            default:          steps_in = '0;
         endcase
      end
   end

   usr_step_cnt #(.CNT_W(CNT_W)) u_cnt (
      .clk      (clk),
      .clear    (clear),
      .load     (accept),
      .load_val (steps_in - ONE),
      .dec      (state == ST_RUN),
      .zero     (cnt_zero)
   );

   // State register.
   always_ff @(posedge clk or negedge clear) begin
      if (!clear)
         state <= ST_IDLE;
      else
         state <= state_nxt;
   end

   // Next state: zero-step commands skip RUN; RUN ends as the last step commits.
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:
            if (accept)
               state_nxt = (steps_in == '0) ? ST_CAPT : ST_RUN;
         ST_RUN:
            if (cnt_zero)
               state_nxt = ST_CAPT;
         ST_CAPT:
            state_nxt = ST_IDLE;
         default:
            state_nxt = ST_IDLE;
      endcase
   end

   // Next values of the registered outputs, keyed on the upcoming state.
   always_comb begin
      s_nxt = S_HOLD;
      if (state_nxt == ST_RUN)
         s_nxt = (state == ST_IDLE) ? op_to_s(bus.cmd_op)
                                    : op_to_s(op_q);
      done_nxt = (state == ST_CAPT);
      err_nxt  = (state == ST_CAPT) && ill_q;
   end

   // Output registers and command capture.
   always_ff @(posedge clk or negedge clear) begin
      if (!clear) begin
         s_q    <= S_HOLD;
         i_q    <= '0;
         res_q  <= '0;
         done_q <= 1'b0;
         err_q  <= 1'b0;
         op_q   <= OP_NOP;
         ill_q  <= 1'b0;
      end else begin
         s_q    <= s_nxt;
         done_q <= done_nxt;
         err_q  <= err_nxt;
         if (state == ST_CAPT)
            res_q <= bus.sr_O;
         if (accept) begin
            op_q  <= bus.cmd_op;
            i_q   <= bus.cmd_data;
            ill_q <= !is_legal(bus.cmd_op);
         end
      end
   end

   assign bus.cmd_ready = (state == ST_IDLE);
   assign bus.sr_S      = s_q;
   assign bus.sr_I      = i_q;
   assign bus.done      = done_q;
   assign bus.err       = err_q;
   assign bus.result    = res_q;
endmodule

// File: tb/tb_usr_cmd_sequencer.sv
// tb_usr_cmd_sequencer: sequencer paired with a behavioural shift register,
// checked against an arithmetic reference of each command's effect.
module tb_usr_cmd_sequencer;

   logic clk;
   logic clear;
   int   total;
   int   bad;
   int   act;
   int   wrong;
   logic [2:0] exp_s;
   logic [3:0] mv;
   logic [3:0] sr_reg;

   usr_cmd_sequencer_if #(.WIDTH(4), .CNT_W(3)) bus ();

   usr_cmd_sequencer #(.WIDTH(4), .CNT_W(3)) dut (
      .clk   (clk),
      .clear (clear),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Universal shift register partner on the shared clk/clear.
   always_ff @(posedge clk or negedge clear) begin
      if (!clear)
         sr_reg <= 4'b0000;
      else
         case (bus.sr_S)
            3'b001:  sr_reg <= {sr_reg[2:0], 1'b0};
            3'b010:  sr_reg <= {1'b0, sr_reg[3:1]};
            3'b011:  sr_reg <= bus.sr_I;
            3'b100:  sr_reg <= ~sr_reg;
            3'b101:  sr_reg <= {sr_reg[2:0], sr_reg[3]};
            3'b110:  sr_reg <= {sr_reg[0], sr_reg[3:1]};
            default: sr_reg <= sr_reg;
         endcase
   end
   assign bus.sr_O = sr_reg;

   // Count cycles with S activity and any S value other than the expected one.
   always @(negedge clk) begin
      if (clear && bus.sr_S !== 3'b000) begin
         act++;
         if (bus.sr_S !== exp_s)
            wrong++;
      end
   end

   task automatic check(input string tag, input logic [7:0] obs,
                        input logic [7:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic bit legal(input logic [2:0] op);
`ifdef USR_SEQ_ROTATE_EN
      return op != 3'd7;
`else
      return op <= 3'd4;
`endif
   endfunction

   function automatic int steps(input logic [2:0] op, input logic [2:0] n);
      if (!legal(op)) return 0;
      case (op)
         3'd1, 3'd4:             return 1;
         3'd2, 3'd3, 3'd5, 3'd6: return int'(n);
         default:                return 0;
      endcase
   endfunction

   function automatic logic [2:0] s_code(input logic [2:0] op);
      case (op)
         3'd1:    return 3'b011;
         3'd2:    return 3'b001;
         3'd3:    return 3'b010;
         3'd4:    return 3'b100;
         3'd5:    return 3'b101;
         3'd6:    return 3'b110;
         default: return 3'b000;
      endcase
   endfunction

   function automatic logic [3:0] ref_next(input logic [3:0] v,
      input logic [2:0] op, input logic [3:0] d, input logic [2:0] n);
      int x;
      int k;
      int r;
      x = int'(v);
      k = int'(n);
      if (!legal(op)) return v;
      case (op)
         3'd1:    r = int'(d);
         3'd2:    r = (x << k) & 15;
         3'd3:    r = x >> k;
         3'd4:    r = (~x) & 15;
         3'd5:    r = ((x << (k % 4)) | (x >> (4 - k % 4))) & 15;
         3'd6:    r = ((x >> (k % 4)) | (x << (4 - k % 4))) & 15;
         default: r = x;
      endcase
      return r[3:0];
   endfunction

   // Issue one command, follow it to done and check latency, S activity
   // and the returned value. hold keeps cmd_valid high with junk fields.
   task automatic do_cmd(input logic [2:0] op, input logic [3:0] d,
                         input logic [2:0] n, input bit hold);
      int st;
      int k;
      logic [3:0] er;
      st = steps(op, n);
      er = ref_next(mv, op, d, n);
      bus.cmd_valid = 1'b1;
      bus.cmd_op    = op;
      bus.cmd_data  = d;
      bus.cmd_count = n;
      exp_s = legal(op) ? s_code(op) : 3'b000;
      act   = 0;
      wrong = 0;
      check("ready_idle", 8'(bus.cmd_ready), 8'd1);
      @(posedge clk);
      #1;
      check("done_low", 8'(bus.done), 8'd0);
      if (!hold) bus.cmd_valid = 1'b0;
      bus.cmd_op    = 3'($urandom);
      bus.cmd_data  = 4'($urandom);
      bus.cmd_count = 3'($urandom);
      k = 0;
      while (k < 20) begin
         check("ready_busy", 8'(bus.cmd_ready), 8'd0);
         @(posedge clk);
         #1;
         k++;
         if (bus.done === 1'b1) break;
      end
      check("done_latency", 8'(k), 8'(st + 1));
      check("ready_done", 8'(bus.cmd_ready), 8'd1);
      check("err", 8'(bus.err), 8'(!legal(op)));
      check("result", 8'(bus.result), 8'(er));
      check("s_cycles", 8'(act), 8'(st));
      check("s_wrong", 8'(wrong), 8'd0);
      mv = er;
   endtask

   initial begin
      total = 0;
      bad   = 0;
      act   = 0;
      wrong = 0;
      exp_s = 3'b000;
      mv    = 4'b0000;
      clear = 1'b0;
      bus.cmd_valid = 1'b0;
      bus.cmd_op    = 3'd0;
      bus.cmd_data  = 4'd0;
      bus.cmd_count = 3'd0;
      #3;
      check("rst_s", 8'(bus.sr_S), 8'd0);
      check("rst_i", 8'(bus.sr_I), 8'd0);
      check("rst_done", 8'(bus.done), 8'd0);
      check("rst_err", 8'(bus.err), 8'd0);
      check("rst_result", 8'(bus.result), 8'd0);
      check("rst_ready", 8'(bus.cmd_ready), 8'd1);
      @(negedge clk);
      clear = 1'b1;

      do_cmd(3'd1, 4'b1011, 3'd0, 1'b0);
      do_cmd(3'd1, 4'b0001, 3'd0, 1'b0);
      do_cmd(3'd2, 4'b0000, 3'd2, 1'b0);
      do_cmd(3'd3, 4'b0000, 3'd1, 1'b0);
      do_cmd(3'd1, 4'b0110, 3'd0, 1'b0);
      do_cmd(3'd4, 4'b0000, 3'd0, 1'b0);
      do_cmd(3'd3, 4'b0000, 3'd7, 1'b0);
      do_cmd(3'd1, 4'b1101, 3'd0, 1'b0);
      do_cmd(3'd2, 4'b0000, 3'd0, 1'b0);
      do_cmd(3'd1, 4'b1000, 3'd0, 1'b0);
      do_cmd(3'd5, 4'b0000, 3'd1, 1'b0);
      do_cmd(3'd6, 4'b0000, 3'd2, 1'b0);
      do_cmd(3'd0, 4'b1111, 3'd3, 1'b1);
      do_cmd(3'd7, 4'b1111, 3'd3, 1'b1);
      do_cmd(3'd1, 4'b0101, 3'd0, 1'b1);
      do_cmd(3'd2, 4'b0000, 3'd5, 1'b0);

      bus.cmd_valid = 1'b1;
      bus.cmd_op    = 3'd3;
      bus.cmd_data  = 4'($urandom);
      bus.cmd_count = 3'd5;
      @(posedge clk);
      #1;
      bus.cmd_valid = 1'b0;
      @(posedge clk);
      #1;
      check("mid_run_s", 8'(bus.sr_S), 8'b010);
      check("mid_run_ready", 8'(bus.cmd_ready), 8'd0);
      #2;
      clear = 1'b0;
      #1;
      check("clr_s", 8'(bus.sr_S), 8'd0);
      check("clr_i", 8'(bus.sr_I), 8'd0);
      check("clr_done", 8'(bus.done), 8'd0);
      check("clr_err", 8'(bus.err), 8'd0);
      check("clr_result", 8'(bus.result), 8'd0);
      check("clr_ready", 8'(bus.cmd_ready), 8'd1);
      mv = 4'b0000;
      @(negedge clk);
      clear = 1'b1;
      do_cmd(3'd1, 4'b0011, 3'd0, 1'b0);

      for (int i = 0; i < 40; i++) begin
         do_cmd(3'($urandom_range(0, 7)), 4'($urandom),
                3'($urandom), (i < 39) ? 1'($urandom) : 1'b0);
      end

      @(posedge clk);
      #1;
      check("done_clears", 8'(bus.done), 8'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
